delay_timer: RTL and testbench

Random-delay countdown stage that consumes the 4-bit pseudo-random value produced by the upstream LFSR. On a start request it captures the LFSR output plus a fixed offset, counts that many time-base ticks, then emits a single-cycle `time_out` pulse. It also issues a one-cycle `lfsr_en` pulse so the LFSR advances to a fresh value for the next run. It sits between the LFSR and the lights/sequencer FSM that waits on `time_out`.

---
 rtl/delay_timer.sv | 106 ++++++++++
 tb/tb_delay_timer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_timer.sv
// Random-delay countdown: captures LFSR value + OFFSET on trigger, counts tick
// cycles down to zero, then emits a single-cycle time_out pulse.
//
// state | meaning
// IDLE  | waiting for trigger; tick/abort ignored
// COUNT | decrementing count on tick; abort cancels
// DONE  | time_out asserted for this one cycle, then back to IDLE
module delay_timer #(
    parameter int WIDTH  = 4,
    parameter int OFFSET = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             abort,
    input  logic             tick,
    input  logic [WIDTH-1:0] rnd,
    output logic             lfsr_en,
    output logic             busy,
    output logic             time_out,
    output logic [WIDTH:0]   count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH:0] CNT_ZERO = '0;
    localparam logic [WIDTH:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] OFS      = OFFSET[WIDTH:0];

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH:0] count_nxt;
    logic [WIDTH:0] load_val;
    logic           lfsr_en_nxt;
    logic           busy_nxt;
    logic           time_out_nxt;

    // One extra bit makes rnd + OFFSET overflow-free.
    assign load_val = {1'b0, rnd} + OFS;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= CNT_ZERO;
            lfsr_en  <= 1'b0;
            busy     <= 1'b0;
            time_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            lfsr_en  <= lfsr_en_nxt;
            busy     <= busy_nxt;
            time_out <= time_out_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        lfsr_en_nxt  = 1'b0;
        time_out_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (trigger) begin
                    count_nxt   = load_val;
                    lfsr_en_nxt = 1'b1;
                    if (load_val == CNT_ZERO) begin
                        state_nxt    = DONE;
                        time_out_nxt = 1'b1;
                    end else begin
                        state_nxt = COUNT;
                    end
                end
            end
            COUNT: begin
                if (abort) begin
                    state_nxt = IDLE;
                    count_nxt = CNT_ZERO;
                end else if (tick && (count != CNT_ZERO)) begin
                    count_nxt = count - CNT_ONE;
                    // Expire on the same edge as the last decrement.
                    if (count == CNT_ONE) begin
                        state_nxt    = DONE;
                        time_out_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                count_nxt = CNT_ZERO;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = CNT_ZERO;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_delay_timer.sv
// Self-checking bench for delay_timer: two instances (OFFSET=1 and OFFSET=0)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_delay_timer;

    logic       clk;
    logic       rst;
    logic       trigger;
    logic       abort;
    logic       tick;
    logic [3:0] rnd;

    logic       lfsr_en_a, busy_a, time_out_a;
    logic [4:0] count_a;
    logic       lfsr_en_b, busy_b, time_out_b;
    logic [4:0] count_b;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    delay_timer #(.WIDTH(4), .OFFSET(1)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .tick(tick),
        .rnd(rnd), .lfsr_en(lfsr_en_a), .busy(busy_a), .time_out(time_out_a),
        .count(count_a)
    );

    delay_timer #(.WIDTH(4), .OFFSET(0)) dut0 (
        .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .tick(tick),
        .rnd(rnd), .lfsr_en(lfsr_en_b), .busy(busy_b), .time_out(time_out_b),
        .count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per instance, remaining ticks, running flag, expiry flag.
    int m_cnt [2];
    bit m_run [2];
    bit m_to  [2];
    bit m_en  [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] <= 0;
                m_run[i] <= 1'b0;
                m_to[i]  <= 1'b0;
                m_en[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic int c = m_cnt[i];
                automatic bit r = m_run[i];
                automatic bit t = m_to[i];
                automatic bit e = 1'b0;
                if (t) begin
                    t = 1'b0;
                    c = 0;
                end else if (r) begin
                    if (abort) begin
                        r = 1'b0;
                        c = 0;
                    end else if (tick) begin
                        c = c - 1;
                        if (c == 0) begin
                            r = 1'b0;
                            t = 1'b1;
                        end
                    end
                end else if (trigger) begin
                    c = int'(rnd) + ((i == 0) ? 1 : 0);
                    e = 1'b1;
                    if (c == 0) t = 1'b1;
                    else        r = 1'b1;
                end
                m_cnt[i] <= c;
                m_run[i] <= r;
                m_to[i]  <= t;
                m_en[i]  <= e;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_count_a",    32'(count_a),    32'(m_cnt[0]));
            check("model_busy_a",     32'(busy_a),     32'(m_run[0] | m_to[0]));
            check("model_time_out_a", 32'(time_out_a), 32'(m_to[0]));
            check("model_lfsr_en_a",  32'(lfsr_en_a),  32'(m_en[0]));
            check("model_count_b",    32'(count_b),    32'(m_cnt[1]));
            check("model_busy_b",     32'(busy_b),     32'(m_run[1] | m_to[1]));
            check("model_time_out_b", 32'(time_out_b), 32'(m_to[1]));
            check("model_lfsr_en_b",  32'(lfsr_en_b),  32'(m_en[1]));
        end
    end

    int ticks;

    initial begin
        rst = 1'b0;
        trigger = 1'b0;
        abort = 1'b0;
        tick = 1'b0;
        rnd = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_count",    32'(count_a),    32'd0);
        check("rst_busy",     32'(busy_a),     32'd0);
        check("rst_time_out", 32'(time_out_a), 32'd0);
        check("rst_lfsr_en",  32'(lfsr_en_a),  32'd0);
        chk_en = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy_a), 32'd0);

        // Basic run: rnd=5, OFFSET=1 -> 6 ticks
        rnd = 4'b0101;
        tick = 1'b1;
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        check("basic_load",    32'(count_a),    32'd6);
        check("basic_lfsr_en", 32'(lfsr_en_a), 32'd1);
        check("basic_busy",    32'(busy_a),     32'd1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("basic_count",   32'(count_a),    32'(6 - k));
            check("basic_lfsr_lo", 32'(lfsr_en_a),  32'd0);
            check("basic_to",      32'(time_out_a), 32'(k == 6));
        end
        @(negedge clk);
        check("basic_busy_end", 32'(busy_a),     32'd0);
        check("basic_to_end",   32'(time_out_a), 32'd0);
        tick = 1'b0;

        // Zero delay on the OFFSET=0 instance
        rnd = 4'h0;
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        check("zero_to",      32'(time_out_b), 32'd1);
        check("zero_lfsr_en", 32'(lfsr_en_b),  32'd1);
        check("zero_count",   32'(count_b),    32'd0);
        check("zero_hold_a",  32'(count_a),    32'd1);
        @(negedge clk);
        check("zero_to_end",   32'(time_out_b), 32'd0);
        check("zero_busy_end", 32'(busy_b),     32'd0);
        check("zero_lfsr_lo",  32'(lfsr_en_b),  32'd0);
        tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;

        // Slow time base with ignored triggers
        rnd = 4'hF;
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        check("slow_load", 32'(count_a), 32'd16);
        ticks = 0;
        for (int c = 0; c < 100 && ticks < 16; c++) begin
            tick = ((c % 4) == 3);
            trigger = ((c % 5) == 1);
            @(posedge clk);
            if (tick) ticks++;
            @(negedge clk);
            check("slow_count",   32'(count_a),    32'(16 - ticks));
            check("slow_to",      32'(time_out_a), 32'(ticks == 16));
            check("slow_lfsr_lo", 32'(lfsr_en_a),  32'd0);
        end
        check("slow_ticks", 32'(ticks), 32'd16);
        tick = 1'b0;
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        check("slow_done_busy", 32'(busy_a),    32'd0);
        check("slow_done_lfsr", 32'(lfsr_en_a), 32'd0);
        check("slow_done_cnt",  32'(count_a),   32'd0);

        // Abort coincident with tick at count=3
        rnd = 4'h2;
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        check("abort_load", 32'(count_a), 32'd3);
        abort = 1'b1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        tick = 1'b0;
        trigger = 1'b1;
        rnd = 4'h9;
        @(negedge clk);
        check("abort_count", 32'(count_a),    32'd0);
        check("abort_busy",  32'(busy_a),     32'd0);
        check("abort_to",    32'(time_out_a), 32'd0);
        @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        check("abort_retrig_cnt",  32'(count_a),   32'd10);
        check("abort_retrig_lfsr", 32'(lfsr_en_a), 32'd1);
        tick = 1'b1;
        repeat (12) @(negedge clk);

        // Asynchronous reset mid-count
        rnd = 4'hA;
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_count",    32'(count_a),    32'd0);
        check("arst_busy",     32'(busy_a),     32'd0);
        check("arst_time_out", 32'(time_out_a), 32'd0);
        check("arst_lfsr_en",  32'(lfsr_en_a),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arst_stay_idle", 32'(busy_a), 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #2;
            trigger = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 19) == 0);
            tick    = (n < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
            rnd     = 4'($urandom_range(0, 15));
            rst     = ($urandom_range(0, 599) != 0);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
